// File: rtl/alu_issue_arb.sv
// alu_issue_arb: round-robin two-port issue arbiter for the shared alu_r.
// Optional illegal-op check enabled by defining ALU_ARB_OPCHK_EN.
module alu_issue_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_d_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            res_id,
  output logic            res_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          st, st_nxt;
  logic            last_grant;
  logic            gnt_any;
  logic            gnt_id;
  logic            slot_free;
  logic            accept;
  logic [3:0]      gop;
  logic [XLEN-1:0] gsrc1;
  logic [XLEN-1:0] gsrc2;
  logic            bad_op;

  assign res_valid = (st == FULL);
  assign slot_free = !res_valid || res_ready;

  // both valid: the one that did not win last time
  assign gnt_any = req0_valid || req1_valid;
  assign gnt_id  = (req0_valid && req1_valid)
                 ? ~last_grant : req1_valid;

  assign accept     = gnt_any && slot_free && rst_n;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  always_comb begin
    gop   = '0;
    gsrc1 = '0;
    gsrc2 = '0;
    if (gnt_any) begin
      gop   = gnt_id ? req1_op   : req0_op;
      gsrc1 = gnt_id ? req1_src1 : req0_src1;
      gsrc2 = gnt_id ? req1_src2 : req0_src2;
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  assign bad_op = gnt_any && (gop > 4'd9);
  assign alu_op = bad_op ? 4'd0 : gop;
`else
  assign bad_op = 1'b0;
  assign alu_op = gop;
`endif

  assign alu_src1 = gsrc1;
  assign alu_src2 = gsrc2;

  always_comb begin
    st_nxt = st;
    unique case (st)
      EMPTY: if (accept) st_nxt = FULL;
      FULL: begin
        if (accept)         st_nxt = FULL;
        else if (res_ready) st_nxt = EMPTY;
      end
      default: st_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= EMPTY;
      res_data   <= '0;
      res_id     <= 1'b0;
      res_err    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      st <= st_nxt;
      if (accept) begin
        res_data   <= bad_op ? '0 : alu_d_out;
        res_id     <= gnt_id;
        res_err    <= bad_op;
        last_grant <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arb.sv
// tb_alu_issue_arb: directed and random checks of alu_issue_arb
// against a behavioural model; honours ALU_ARB_OPCHK_EN.
module tb_alu_issue_arb;

`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_src1 = '0, req0_src2 = '0;
  logic [31:0] req1_src1 = '0, req1_src2 = '0;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1, alu_src2, alu_d_out;
  logic        res_valid, res_id, res_err;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;

  int n_cmp = 0;
  int n_bad = 0;

  // expected visible state
  logic        m_valid, m_id, m_err, m_last;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return {31'd0, $signed(a) < $signed(b)};
      4'd9: return {31'd0, a < b};
      default: return a ^ b ^ 32'hdead_beef;
    endcase
  endfunction

  assign alu_d_out = alu_f(alu_op, alu_src1, alu_src2);

  alu_issue_arb #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_src1(req0_src1),
    .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_src1(req1_src1),
    .req1_src2(req1_src2),
    .alu_op(alu_op), .alu_src1(alu_src1),
    .alu_src2(alu_src2), .alu_d_out(alu_d_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .res_err(res_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 1'b0;
    m_err   = 1'b0;
    m_last  = 1'b1;
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_valid"}, {31'd0, res_valid}, {31'd0, m_valid});
    chk({tag, "_data"},  res_data, m_data);
    chk({tag, "_id"},    {31'd0, res_id}, {31'd0, m_id});
    chk({tag, "_err"},   {31'd0, res_err}, {31'd0, m_err});
  endtask

  // one clock: called just after a negedge with inputs set
  task automatic step(output logic a0, output logic a1);
    logic        any, id, free, e0, e1, bad;
    logic [3:0]  op;
    logic [31:0] s1, s2, r;
    #1;
    any  = req0_valid | req1_valid;
    id   = (req0_valid & req1_valid) ? ~m_last : req1_valid;
    free = !m_valid || res_ready;
    e0   = any && free && !id;
    e1   = any && free && id;
    op   = !any ? 4'd0 : (id ? req1_op : req0_op);
    s1   = !any ? 32'd0 : (id ? req1_src1 : req0_src1);
    s2   = !any ? 32'd0 : (id ? req1_src2 : req0_src2);
    bad  = OPCHK && any && (op > 4'd9);
    r    = bad ? 32'd0 : alu_f(op, s1, s2);
    chk("rdy0", {31'd0, req0_ready}, {31'd0, e0});
    chk("rdy1", {31'd0, req1_ready}, {31'd0, e1});
    chk("alu_op", {28'd0, alu_op}, {28'd0, bad ? 4'd0 : op});
    chk("alu_src1", alu_src1, s1);
    chk("alu_src2", alu_src2, s2);
    @(posedge clk);
    if (e0 || e1) begin
      m_valid = 1'b1;
      m_data  = r;
      m_id    = id;
      m_err   = bad;
      m_last  = id;
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
    a0 = e0;
    a1 = e1;
    @(negedge clk);
    chk_res("res");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        a0, a1;
  logic [31:0] hold_d;
  logic [31:0] ids [4];
  logic [31:0] dat [4];
  int          cnt1;
  logic        p0, p1;

  initial begin
    do_reset();
    #1;
    chk_res("reset");
    chk("reset_rdy0", {31'd0, req0_ready}, 32'd0);

    // single request
    req0_valid = 1; req0_op = 4'd0;
    req0_src1 = 5; req0_src2 = 7;
    res_ready = 1;
    #4;
    step(a0, a1);
    chk("t1_acc", {31'd0, a0}, 32'd1);
    chk("t1_data", res_data, 32'd12);
    chk("t1_id", {31'd0, res_id}, 32'd0);
    req0_valid = 0;
    step(a0, a1);

    // contention from fresh reset
    do_reset();
    req0_valid = 1; req0_op = 4'd0;
    req0_src1 = 1; req0_src2 = 1;
    req1_valid = 1; req1_op = 4'd1;
    req1_src1 = 9; req1_src2 = 4;
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step(a0, a1);
      ids[i] = {31'd0, res_id};
      dat[i] = res_data;
    end
    for (int i = 0; i < 4; i++) begin
      chk("cont_id", ids[i], (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("cont_data", dat[i], (i % 2 == 0) ? 32'd2 : 32'd5);
    end
    req0_valid = 0; req1_valid = 0;
    step(a0, a1);

    // backpressure
    req0_valid = 1; req0_src1 = 2; req0_src2 = 3;
    step(a0, a1);
    req0_valid = 0;
    req1_valid = 1; req1_op = 4'd1;
    req1_src1 = 20; req1_src2 = 6;
    res_ready = 0;
    hold_d = res_data;
    for (int i = 0; i < 3; i++) begin
      step(a0, a1);
      chk("bp_stall", {31'd0, a1}, 32'd0);
      chk("bp_hold", res_data, hold_d);
    end
    res_ready = 1;
    step(a0, a1);
    chk("bp_acc", {31'd0, a1}, 32'd1);
    chk("bp_id", {31'd0, res_id}, 32'd1);
    chk("bp_data", res_data, 32'd14);
    req1_valid = 0;

    // reset mid-operation with a held result
    req0_valid = 1; req0_op = 4'd0;
    req0_src1 = 1; req0_src2 = 2;
    req1_valid = 1; req1_src1 = 8; req1_src2 = 3;
    res_ready = 0;
    @(posedge clk);
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("mid_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("mid_rdy1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    res_ready = 1;
    step(a0, a1);
    chk("mid_first", {31'd0, res_id}, 32'd0);
    req0_valid = 0; req1_valid = 0;
    step(a0, a1);

    // illegal op
    req0_valid = 1; req0_op = 4'b1100;
    req0_src1 = 3; req0_src2 = 4;
    #4;
    chk("ill_aluop", {28'd0, alu_op},
        OPCHK ? 32'd0 : 32'd12);
    step(a0, a1);
    chk("ill_err", {31'd0, res_err}, {31'd0, OPCHK});
    chk("ill_data", res_data,
        OPCHK ? 32'd0 : (32'd3 ^ 32'd4 ^ 32'hdead_beef));
    req0_valid = 0;

    // hold across a 5-cycle stall
    req1_valid = 1; req1_op = 4'd0;
    req1_src1 = 10; req1_src2 = 20;
    res_ready = 0;
    cnt1 = 0;
    for (int i = 0; i < 5; i++) begin
      step(a0, a1);
      if (a1) cnt1++;
    end
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step(a0, a1);
      if (a1) begin
        cnt1++;
        req1_valid = 0;
      end
    end
    chk("hold_cnt", cnt1, 32'd1);
    chk("hold_id", {31'd0, res_id}, 32'd1);
    chk("hold_data", res_data, 32'd30);
    chk("hold_vld", {31'd0, req1_valid}, 32'd0);

    // random traffic
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1;
        req0_op   = ($urandom_range(7, 0) == 0)
                  ? 4'($urandom_range(15, 10))
                  : 4'($urandom_range(9, 0));
        req0_src1 = $urandom;
        req0_src2 = $urandom;
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1;
        req1_op   = 4'($urandom_range(15, 0));
        req1_src1 = $urandom;
        req1_src2 = $urandom;
      end
      req0_valid = p0;
      req1_valid = p1;
      res_ready  = ($urandom_range(9, 0) < 7);
      step(a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
      req0_valid = p0;
      req1_valid = p1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
